vid_timing_detect: RTL and testbench
====================================

VID_TIMING_DETECT -- requirements
Module: vid_timing_detect

Interface
REQ-001 SHALL have port clk, input, 1 -- pixel clock; all logic on rising edge.
REQ-002 SHALL have port reset_n, input, 1 -- reset, synchronous, active-low.
REQ-003 SHALL have ports vid_hs, vid_vs, vid_de, input, 1 each -- active-high sync pulses and data enable.
REQ-004 SHALL have ports vid_r, vid_g, vid_b, input, 8 each -- pixel data, meaningful only while vid_de=1.
REQ-005 SHALL have outputs meas_h_total, meas_h_sync, meas_h_active, meas_v_total, meas_v_sync, meas_v_active, 12 each -- measured timing, in clocks for h and lines for v.
REQ-006 SHALL have output locked, 1 -- stable timing detected.
REQ-007 SHALL have output meas_valid, 1 -- one-cycle pulse at each frame end while locked.
REQ-008 SHALL have output det_mode, 4 -- resolution code: 0=640x480, 1=720x480, 2=1024x768, 3=1280x1024, 4=1920x1080, 15=unknown.
REQ-009 SHALL have output frame_sum, 16 -- active-pixel checksum; present only with VTD_CHECKSUM_EN.
REQ-010 SHALL have parameter TIMEOUT, default 22'h3FFFFF -- clocks without a vs rising edge before unlock.

Function
REQ-011 SHALL register hs, vs and de once and detect rising edges on the registered copies; all counts refer to the registered signals.
REQ-012 SHALL define a frame as the interval between consecutive vs rising edges.
REQ-013 h_total SHALL be the clock count between the first and second hs rising edges after a vs rising edge.
REQ-014 h_sync SHALL be the count of hs-high clocks in the first line of the frame.
REQ-015 h_active SHALL be the count of de-high clocks in the first line containing de.
REQ-016 v_total SHALL be the count of hs rising edges in the frame.
REQ-017 v_sync SHALL be the count of hs rising edges sampled while vs is high.
REQ-018 v_active SHALL be the count of lines containing at least one de-high clock.
REQ-019 All counters SHALL saturate at 4095 and set a frame-invalid flag; an invalid frame SHALL never match.
REQ-020 SHALL implement FSM SEARCH -> MEASURE -> CHECK -> LOCKED:
- SEARCH: waits for vs rising edge, then goes to MEASURE.
- MEASURE: counts one frame; at the next vs rise latches the six values as the previous set and goes to CHECK.
- CHECK: counts the next frame; at the next vs rise, if all six values equal the previous set, goes to LOCKED and updates the outputs; otherwise stores the new set and stays in CHECK.
- LOCKED: at each vs rise compares with the held set; on match pulses meas_valid; on mismatch clears locked, stores the new set and goes to CHECK.
REQ-021 Outputs SHALL update one clock after the deciding vs rising edge; locked SHALL assert in the same cycle as the outputs update.
REQ-022 A vs rising edge SHALL always close the current frame and open the next one in the same cycle, without losing that edge.
REQ-023 det_mode SHALL be decoded from (meas_h_active, meas_v_active) exact match; any other pair SHALL give 15.
REQ-024 A watchdog SHALL count clocks since the last vs rise; reaching TIMEOUT in any state SHALL force SEARCH, locked=0, and all measurement outputs to 0.

Reset
REQ-025 With reset_n=0 at a clock edge: FSM=SEARCH, all counters and measurement outputs=0, locked=0, meas_valid=0, det_mode=15, frame_sum=0.
REQ-026 Reset mid-frame SHALL discard partial counts; measurement restarts at the next vs rising edge after release.

Configuration
REQ-027 With macro VTD_CHECKSUM_EN defined: the block SHALL accumulate r+g+b of every de-high pixel modulo 2^16 per frame; frame_sum SHALL load at each meas_valid pulse.
REQ-028 Without VTD_CHECKSUM_EN: no checksum port or logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-029 640x480 frames (800x525, hs 96, vs 2, de 640x480) -> locked=1 one clock after the 3rd vs rise; outputs 800/96/640/525/2/480; det_mode=0.
REQ-030 Locked on 640x480, switch to 1920x1080 (2200x1125, hs 44, vs 5) -> locked=0 at the first changed frame end; relock at the next frame end with det_mode=4.
REQ-031 Stop vs for TIMEOUT clocks while locked -> locked=0, outputs=0, FSM=SEARCH; resumed vs relocks after 2 frames.
REQ-032 Assert reset_n=0 for 1 clock mid-frame while locked -> all outputs at reset values next clock; relock after 2 full frames.
REQ-033 VTD_CHECKSUM_EN, 640x480 with constant pixel r=g=b=1 -> frame_sum = 307200*3 mod 65536 = 4096 at each meas_valid.
REQ-034 h_active=800 with v_active=600 -> det_mode=15, locked=1.

Source files
------------

// File: rtl/vid_timing_detect.sv
`timescale 1ns/1ps
// Video timing detector: measures h/v timing of an incoming stream and locks when consecutive frames
// agree. Define VTD_CHECKSUM_EN to add the per-frame active-pixel checksum output frame_sum.
module vid_timing_detect #(
    parameter logic [21:0] TIMEOUT = 22'h3FFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic        vid_de,
    input  logic [7:0]  vid_r,
    input  logic [7:0]  vid_g,
    input  logic [7:0]  vid_b,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_h_sync,
    output logic [11:0] meas_h_active,
    output logic [11:0] meas_v_total,
    output logic [11:0] meas_v_sync,
    output logic [11:0] meas_v_active,
    output logic        locked,
    output logic        meas_valid,
    output logic [3:0]  det_mode
`ifdef VTD_CHECKSUM_EN
    ,
    output logic [15:0] frame_sum
`endif
);

    typedef enum logic [1:0] {StSearch, StMeasure, StCheck, StLocked} state_e;

    localparam logic [11:0] CntMax = 12'hFFF;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == CntMax) ? v : v + 12'd1;
    endfunction

    state_e      state_q;
    logic        hs_q, vs_q, de_q, hs_p, vs_p;
    logic        hs_rise, vs_rise;
    logic [11:0] vt_q, vt_d, vsc_q, vsc_d, va_q, va_d;
    logic [11:0] hsc_q, hsc_d, ha_q, ha_d;
    logic [11:0] ht_cnt_q, ht_cnt_d, ht_val_q, ht_val_d;
    logic        ht_run_q, ht_run_d, ht_done_q, ht_done_d;
    logic        line_de_q, line_de_d, inv_q, inv_d;
    logic [21:0] wd_q, wd_d;
    logic        timeout;
    logic [71:0] cur_set, prev_q;
    logic        prev_inv_q, set_match;

    assign hs_rise = hs_q & ~hs_p;
    assign vs_rise = vs_q & ~vs_p;
    assign timeout = (wd_q == TIMEOUT);

    // The closing frame's counts are the _q values; on a vs rise the current cycle already
    // belongs to the new frame, so every counter restarts from zero before adding it.
    always_comb begin
        vt_d      = vs_rise ? '0 : vt_q;
        vsc_d     = vs_rise ? '0 : vsc_q;
        va_d      = vs_rise ? '0 : va_q;
        hsc_d     = vs_rise ? '0 : hsc_q;
        ha_d      = vs_rise ? '0 : ha_q;
        ht_cnt_d  = vs_rise ? '0 : ht_cnt_q;
        ht_val_d  = vs_rise ? '0 : ht_val_q;
        ht_run_d  = vs_rise ? 1'b0 : ht_run_q;
        ht_done_d = vs_rise ? 1'b0 : ht_done_q;
        line_de_d = (vs_rise | hs_rise) ? 1'b0 : line_de_q;

        if (hs_rise) vt_d = sat_inc(vt_d);
        if (hs_rise && vs_q) vsc_d = sat_inc(vsc_d);
        if (de_q && !line_de_d) va_d = sat_inc(va_d);
        line_de_d = line_de_d | de_q;
        if (hs_q && vt_d == 12'd1) hsc_d = sat_inc(hsc_d);
        if (de_q && va_d == 12'd1) ha_d = sat_inc(ha_d);

        if (ht_run_d) begin
            if (hs_rise) begin
                ht_run_d  = 1'b0;
                ht_done_d = 1'b1;
                ht_val_d  = ht_cnt_d;
            end else begin
                ht_cnt_d = sat_inc(ht_cnt_d);
            end
        end else if (hs_rise && !ht_done_d) begin
            ht_run_d = 1'b1;
            ht_cnt_d = 12'd1;
        end

        inv_d = (vs_rise ? 1'b0 : inv_q) | (vt_d == CntMax) | (vsc_d == CntMax) |
                (va_d == CntMax) | (hsc_d == CntMax) | (ha_d == CntMax) | (ht_cnt_d == CntMax);

        if (vs_rise)      wd_d = '0;
        else if (timeout) wd_d = wd_q;
        else              wd_d = wd_q + 22'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            hs_p      <= 1'b0;
            vs_p      <= 1'b0;
            vt_q      <= '0;
            vsc_q     <= '0;
            va_q      <= '0;
            hsc_q     <= '0;
            ha_q      <= '0;
            ht_cnt_q  <= '0;
            ht_val_q  <= '0;
            ht_run_q  <= 1'b0;
            ht_done_q <= 1'b0;
            line_de_q <= 1'b0;
            inv_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            hs_q      <= vid_hs;
            vs_q      <= vid_vs;
            de_q      <= vid_de;
            hs_p      <= hs_q;
            vs_p      <= vs_q;
            vt_q      <= vt_d;
            vsc_q     <= vsc_d;
            va_q      <= va_d;
            hsc_q     <= hsc_d;
            ha_q      <= ha_d;
            ht_cnt_q  <= ht_cnt_d;
            ht_val_q  <= ht_val_d;
            ht_run_q  <= ht_run_d;
            ht_done_q <= ht_done_d;
            line_de_q <= line_de_d;
            inv_q     <= inv_d;
            wd_q      <= wd_d;
        end
    end

`ifdef VTD_CHECKSUM_EN
    logic [7:0]  r_q, g_q, b_q;
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = vs_rise ? '0 : sum_q;
        if (de_q) sum_d = sum_d + {8'd0, r_q} + {8'd0, g_q} + {8'd0, b_q};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else begin
            r_q   <= vid_r;
            g_q   <= vid_g;
            b_q   <= vid_b;
            sum_q <= sum_d;
        end
    end
`else
    logic unused_pix;
    assign unused_pix = ^{vid_r, vid_g, vid_b};
`endif

    assign cur_set   = {ht_val_q, hsc_q, ha_q, vt_q, vsc_q, va_q};
    assign set_match = (cur_set == prev_q) & ~inv_q & ~prev_inv_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StSearch;
            prev_q     <= '0;
            prev_inv_q <= 1'b0;
            locked     <= 1'b0;
            meas_valid <= 1'b0;
            {meas_h_total, meas_h_sync, meas_h_active,
             meas_v_total, meas_v_sync, meas_v_active} <= '0;
`ifdef VTD_CHECKSUM_EN
            frame_sum  <= '0;
`endif
        end else begin
            meas_valid <= 1'b0;
            if (timeout) begin
                // A vs edge arriving on the timeout cycle still opens a measurement.
                state_q <= vs_rise ? StMeasure : StSearch;
                locked  <= 1'b0;
                {meas_h_total, meas_h_sync, meas_h_active,
                 meas_v_total, meas_v_sync, meas_v_active} <= '0;
`ifdef VTD_CHECKSUM_EN
                frame_sum <= '0;
`endif
            end else if (vs_rise) begin
                unique case (state_q)
                    StSearch: state_q <= StMeasure;
                    StMeasure: begin
                        prev_q     <= cur_set;
                        prev_inv_q <= inv_q;
                        state_q    <= StCheck;
                    end
                    StCheck, StLocked: begin
                        if (set_match) begin
                            state_q    <= StLocked;
                            locked     <= 1'b1;
                            meas_valid <= 1'b1;
                            {meas_h_total, meas_h_sync, meas_h_active,
                             meas_v_total, meas_v_sync, meas_v_active} <= cur_set;
`ifdef VTD_CHECKSUM_EN
                            frame_sum <= sum_q;
`endif
                        end else begin
                            prev_q     <= cur_set;
                            prev_inv_q <= inv_q;
                            locked     <= 1'b0;
                            state_q    <= StCheck;
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end
        end
    end

    always_comb begin
        unique case ({meas_h_active, meas_v_active})
            {12'd640,  12'd480}:  det_mode = 4'd0;
            {12'd720,  12'd480}:  det_mode = 4'd1;
            {12'd1024, 12'd768}:  det_mode = 4'd2;
            {12'd1280, 12'd1024}: det_mode = 4'd3;
            {12'd1920, 12'd1080}: det_mode = 4'd4;
            default:              det_mode = 4'd15;
        endcase
    end

endmodule

// File: tb/tb_vid_timing_detect.sv
`timescale 1ns/1ps
// Scoreboard bench for vid_timing_detect: compressed frames (one full-width first line, then 3-clock
// lines) keep real h_active/v_active pairs while staying short.
module tb_vid_timing_detect;

    localparam logic [21:0] TO = 22'd6000;
    localparam int KNone = 0, KLock = 1, KMatch = 2, KUnlock = 3;

    typedef struct {
        int htot; int hsw; int hact; int vtot; int vsw; int vact; int det;
    } tim_t;

    typedef struct {
        int   cyc;
        bit   exp_valid;
        bit   exp_locked;
        tim_t t;
    } exp_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        vid_hs = 1'b0, vid_vs = 1'b0, vid_de = 1'b0;
    logic [7:0]  vid_r = '0, vid_g = '0, vid_b = '0;
    logic [11:0] meas_h_total, meas_h_sync, meas_h_active;
    logic [11:0] meas_v_total, meas_v_sync, meas_v_active;
    logic        locked, meas_valid;
    logic [3:0]  det_mode;
`ifdef VTD_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif

    vid_timing_detect #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .vid_hs        (vid_hs),
        .vid_vs        (vid_vs),
        .vid_de        (vid_de),
        .vid_r         (vid_r),
        .vid_g         (vid_g),
        .vid_b         (vid_b),
        .meas_h_total  (meas_h_total),
        .meas_h_sync   (meas_h_sync),
        .meas_h_active (meas_h_active),
        .meas_v_total  (meas_v_total),
        .meas_v_sync   (meas_v_sync),
        .meas_v_active (meas_v_active),
        .locked        (locked),
        .meas_valid    (meas_valid),
        .det_mode      (det_mode)
`ifdef VTD_CHECKSUM_EN
        ,
        .frame_sum     (frame_sum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    tim_t mode_a = '{800, 96, 640, 525, 2, 480, 0};
    tim_t mode_b = '{2200, 44, 1920, 1125, 5, 1080, 4};
    tim_t mode_c = '{1056, 128, 800, 628, 4, 600, 15};

    exp_t sb[$];
    int   n_vec = 0, n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int cy, input bit v, input bit l, input tim_t e);
        exp_t x;
        x.cyc = cy;
        x.exp_valid = v;
        x.exp_locked = l;
        x.t = e;
        sb.push_back(x);
    endtask

    task automatic drive(input logic hs, input logic vs, input logic de);
        @(posedge clk);
        #1;
        vid_hs = hs;
        vid_vs = vs;
        vid_de = de;
        vid_r  = de ? 8'd1 : 8'hA5;
        vid_g  = de ? 8'd1 : 8'h5A;
        vid_b  = de ? 8'd1 : 8'hC3;
    endtask

    // kind says what the vs rise opening this frame should produce for the frame it closes (e).
    task automatic gen_frame(input tim_t t, input int kind, input tim_t e, output int c0);
        int   len;
        logic hs, de;
        c0 = 0;
        for (int l = 0; l < t.vtot; l++) begin
            len = (l == 0) ? t.htot : 3;
            for (int c = 0; c < len; c++) begin
                if (l == 0) begin
                    hs = (c < t.hsw);
                    de = (c >= t.htot - t.hact);
                end else begin
                    hs = (c == 0);
                    de = (c == 1) && (l < t.vact);
                end
                drive(hs, l < t.vsw, de);
                if (l == 0 && c == 0) begin
                    c0 = cyc;
                    case (kind)
                        KLock: begin
                            push_exp(c0 + 1, 1'b0, 1'b0, e);
                            push_exp(c0 + 2, 1'b1, 1'b1, e);
                        end
                        KMatch: begin
                            push_exp(c0 + 1, 1'b0, 1'b1, e);
                            push_exp(c0 + 2, 1'b1, 1'b1, e);
                        end
                        KUnlock: begin
                            push_exp(c0 + 1, 1'b0, 1'b1, e);
                            push_exp(c0 + 2, 1'b0, 1'b0, e);
                        end
                        default: ;
                    endcase
                end
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_det_mode"}, int'(det_mode), 15);
        check({tag, "_h_total"}, int'(meas_h_total), 0);
        check({tag, "_h_active"}, int'(meas_h_active), 0);
        check({tag, "_v_active"}, int'(meas_v_active), 0);
`ifdef VTD_CHECKSUM_EN
        check({tag, "_frame_sum"}, int'(frame_sum), 0);
`endif
    endtask

    exp_t mon_x;
    bit   mon_hit;

    always @(negedge clk) begin
        mon_hit = 1'b0;
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_x = sb.pop_front();
            check("sb_cycle", cyc, mon_x.cyc);
            check("meas_valid", int'(meas_valid), int'(mon_x.exp_valid));
            check("locked", int'(locked), int'(mon_x.exp_locked));
            if (mon_x.exp_valid) begin
                mon_hit = 1'b1;
                check("h_total", int'(meas_h_total), mon_x.t.htot);
                check("h_sync", int'(meas_h_sync), mon_x.t.hsw);
                check("h_active", int'(meas_h_active), mon_x.t.hact);
                check("v_total", int'(meas_v_total), mon_x.t.vtot);
                check("v_sync", int'(meas_v_sync), mon_x.t.vsw);
                check("v_active", int'(meas_v_active), mon_x.t.vact);
                check("det_mode", int'(det_mode), mon_x.t.det);
`ifdef VTD_CHECKSUM_EN
                check("frame_sum", int'(frame_sum),
                      ((mon_x.t.hact + mon_x.t.vact - 1) * 3) % 65536);
`endif
            end
        end else if (meas_valid) begin
            check("unexpected_meas_valid", int'(meas_valid), 0);
        end
    end

    initial begin
        int c0;
        reset_n = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_cleared("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) drive(1'b0, 1'b0, 1'b0);

        // Acquire 640x480, then stay locked one frame.
        gen_frame(mode_a, KNone, mode_a, c0);
        gen_frame(mode_a, KNone, mode_a, c0);
        gen_frame(mode_a, KLock, mode_a, c0);
        gen_frame(mode_a, KMatch, mode_a, c0);

        // Switch to 1920x1080: unlock at first changed frame end, relock at the next.
        gen_frame(mode_b, KMatch, mode_a, c0);
        gen_frame(mode_b, KUnlock, mode_b, c0);
        gen_frame(mode_b, KLock, mode_b, c0);

        // 800x600-active is not a known mode but must still lock.
        gen_frame(mode_c, KMatch, mode_b, c0);
        gen_frame(mode_c, KUnlock, mode_c, c0);
        gen_frame(mode_c, KLock, mode_c, c0);
        drive(1'b0, 1'b0, 1'b0);

        // Watchdog: vs stops after the last frame start.
        while (cyc < c0 + 2 + int'(TO)) @(negedge clk);
        check("pre_timeout_locked", int'(locked), 1);
        check("pre_timeout_h_active", int'(meas_h_active), mode_c.hact);
        @(negedge clk);
        check_cleared("timeout");

        gen_frame(mode_a, KNone, mode_a, c0);
        gen_frame(mode_a, KNone, mode_a, c0);
        gen_frame(mode_a, KLock, mode_a, c0);

        // One-clock reset in the middle of a locked frame.
        fork
            gen_frame(mode_a, KMatch, mode_a, c0);
            begin
                repeat (1500) @(posedge clk);
                @(negedge clk);
                check("pre_reset_locked", int'(locked), 1);
                @(posedge clk);
                #1 reset_n = 1'b0;
                @(posedge clk);
                #1 reset_n = 1'b1;
                @(negedge clk);
                check_cleared("midframe_reset");
            end
        join
        gen_frame(mode_a, KNone, mode_a, c0);
        gen_frame(mode_a, KNone, mode_a, c0);
        gen_frame(mode_a, KLock, mode_a, c0);

        repeat (8) drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
